// File: rtl/full_adder_core.sv
// full_adder_core: ripple-carry adder of full-adder cells with combinational sum/carry
// and a one-cycle registered copy carrying a valid flag.
module full_adder_core #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             en,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic [WIDTH-1:0] s_q,
  output logic             c_out_q,
  output logic             valid_q
);
  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] r_s;
  logic             r_c;
  logic             r_v;
  assign w_c[0] = c_in;
  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      assign s[i]     = a[i] ^ b[i] ^ w_c[i];
      assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end
  endgenerate
  assign c_out = w_c[WIDTH];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s <= '0;
      r_c <= 1'b0;
      r_v <= 1'b0;
    end else begin
      r_v <= en;
      if (en) begin
        r_s <= s;
        r_c <= c_out;
      end
    end
  end
  assign s_q     = r_s;
  assign c_out_q = r_c;
  assign valid_q = r_v;
endmodule

// File: tb/tb_full_adder_core.sv
// tb_full_adder_core: table-driven check of 1-bit and 8-bit adders plus directed
// sequences for the registered path and asynchronous reset.
module tb_full_adder_core;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       a1, b1, c1;
  logic       s1, co1, sq1, coq1, vq1;
  logic [7:0] a8, b8, s8, sq8;
  logic       c8, co8, coq8, vq8;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  full_adder_core #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .c_in(c1), .en(en),
    .s(s1), .c_out(co1), .s_q(sq1), .c_out_q(coq1), .valid_q(vq1)
  );
  full_adder_core #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .c_in(c8), .en(en),
    .s(s8), .c_out(co8), .s_q(sq8), .c_out_q(coq8), .valid_q(vq8)
  );

  typedef struct {
    logic [2:0] abc;
    logic       s;
    logic       co;
  } vec1_t;
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] s;
    logic       co;
  } vec8_t;

  vec1_t t1[8];
  vec8_t t8[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    t1[0] = '{3'b000, 1'b0, 1'b0};
    t1[1] = '{3'b001, 1'b1, 1'b0};
    t1[2] = '{3'b010, 1'b1, 1'b0};
    t1[3] = '{3'b011, 1'b0, 1'b1};
    t1[4] = '{3'b100, 1'b1, 1'b0};
    t1[5] = '{3'b101, 1'b0, 1'b1};
    t1[6] = '{3'b110, 1'b0, 1'b1};
    t1[7] = '{3'b111, 1'b1, 1'b1};
    t8[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    t8[1] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    t8[2] = '{8'h3C, 8'h42, 1'b1, 8'h7F, 1'b0};
    t8[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    t8[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    t8[5] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1};
    t8[6] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    t8[7] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

    // Reset held low with en high: combinational path works, registers stay clear.
    rst_n = 1'b0; en = 1'b1;
    a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      {a1, b1, c1} = t1[i].abc;
      #10;
      chk($sformatf("rst_s1[%0d]", i), 32'(s1), 32'(t1[i].s));
      chk($sformatf("rst_co1[%0d]", i), 32'(co1), 32'(t1[i].co));
      chk($sformatf("rst_regs1[%0d]", i), {29'd0, sq1, coq1, vq1}, 32'd0);
      chk($sformatf("rst_regs8[%0d]", i), {22'd0, sq8, coq8, vq8}, 32'd0);
    end

    @(negedge clk);
    rst_n = 1'b1; en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      {a1, b1, c1} = t1[i].abc;
      a8 = t8[i].a; b8 = t8[i].b; c8 = t8[i].ci;
      #3;
      chk($sformatf("tt_s1[%0d]", i), 32'(s1), 32'(t1[i].s));
      chk($sformatf("tt_co1[%0d]", i), 32'(co1), 32'(t1[i].co));
      chk($sformatf("add8_s[%0d]", i), 32'(s8), 32'(t8[i].s));
      chk($sformatf("add8_co[%0d]", i), 32'(co8), 32'(t8[i].co));
    end

    // One-cycle capture followed by a hold cycle.
    @(negedge clk);
    a8 = 8'h3C; b8 = 8'h42; c8 = 1'b1; en = 1'b1;
    @(posedge clk); #1;
    chk("cap_sq", 32'(sq8), 32'h7F);
    chk("cap_coq", 32'(coq8), 32'd0);
    chk("cap_vq", 32'(vq8), 32'd1);
    en = 1'b0; a8 = 8'hFF; b8 = 8'h01; c8 = 1'b0;
    @(posedge clk); #1;
    chk("hold_vq", 32'(vq8), 32'd0);
    chk("hold_sq", 32'(sq8), 32'h7F);
    chk("hold_coq", 32'(coq8), 32'd0);
    en = 1'b1;
    @(posedge clk); #1;
    chk("cap2_sq", 32'(sq8), 32'h00);
    chk("cap2_coq", 32'(coq8), 32'd1);
    chk("cap2_vq", 32'(vq8), 32'd1);
    a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
    @(posedge clk); #1;
    chk("cap3_sq", 32'(sq8), 32'hFF);
    chk("cap3_coq", 32'(coq8), 32'd1);

    // Asynchronous reset between edges clears at once.
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", {22'd0, sq8, coq8, vq8}, 32'd0);
    @(posedge clk); #1;
    chk("rst_hold", {22'd0, sq8, coq8, vq8}, 32'd0);
    chk("rst_comb_s", 32'(s8), 32'hFF);
    chk("rst_comb_co", 32'(co8), 32'd1);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_sq", 32'(sq8), 32'hFF);
    chk("post_rst_vq", 32'(vq8), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
